// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-port integer register file with a pending-write scoreboard
//
// This replaces the fixed two-read-port register array in the decode stage.
// Register 0 is hardwired to zero. It never stores a write and never shows busy.
// Every register also has a busy bit. An issue to a register sets the bit, and a
// writeback to that register clears it. If both happen on the same register in
// the same cycle, the set wins, because the newer producer supersedes the older.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   : same-cycle writes are forwarded to the read ports, using the
//               highest-index write port. The forwarded clear of the busy bit is
//               also visible, unless the same register is being issued this cycle.
//   undefined : the read ports see only the storage and busy bits from before
//               the clock edge.
//
// Parameters:
//   XLEN  data width
//   NREG  number of registers (power of two, >= 2)
//   NRD   number of read ports
//   NWR   number of write ports; a higher index wins a same-address conflict
//   AW    address width, derived from NREG
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   rd_addr      read addresses, port i at [i*AW +: AW]
//   rd_data      combinational read data, port i at [i*XLEN +: XLEN]
//   rd_busy      combinational busy bit of each addressed register
//   wr_en        write enables, one per write port
//   wr_addr      write addresses, port j at [j*AW +: AW]
//   wr_data      write data, port j at [j*XLEN +: XLEN]
//   issue_valid  an instruction that writes issue_rd issues this cycle
//   issue_rd     destination register of the issuing instruction
//   dbg_regs     flat storage image, register r at [r*XLEN +: XLEN]
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  output logic [NREG*XLEN-1:0] dbg_regs
);

  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0][XLEN-1:0] regs_d;
  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0]           busy_d;

  // Next storage and scoreboard state: writes, then clears, then issue sets
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    // Ports are applied in ascending order, so the highest index overwrites the rest
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end else begin
        regs_d = regs_d;
      end
    end
    // The issue set comes after the writeback clear, so a new producer keeps busy high
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    regs_d[0] = {XLEN{1'b0}};
    busy_d[0] = 1'b0;
  end

  // Storage and busy-bit registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // The debug image is the raw storage and never includes forwarded data
  assign dbg_regs = regs_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr_s;
    logic [XLEN-1:0] data_s;
    logic            busy_s;

    assign addr_s = rd_addr[i*AW +: AW];

    // Per-port read mux, with optional forwarding of same-cycle writes
    always_comb begin
      data_s = regs_q[addr_s];
      busy_s = busy_q[addr_s];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == addr_s)) begin
          data_s = wr_data[j*XLEN +: XLEN];
          // The forwarded writeback clears busy unless a new producer issues now
          busy_s = issue_valid && (issue_rd == addr_s);
        end else begin
          data_s = data_s;
        end
      end
`endif
      // Reset also masks any write data that would otherwise be forwarded
      if (reset || (addr_s == '0)) begin
        data_s = {XLEN{1'b0}};
        busy_s = 1'b0;
      end else begin
        busy_s = busy_s;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data_s;
    assign rd_busy[i]              = busy_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int NRD  = 3;
  localparam int NWR  = 2;
  localparam int AW   = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic [NREG*XLEN-1:0] dbg_regs;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .dbg_regs(dbg_regs)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_reg [NREG];
  logic            m_busy [NREG];

  function automatic int wa(input int j);
    return int'(wr_addr[j*AW +: AW]);
  endfunction

  function automatic logic [XLEN-1:0] wd(input int j);
    return wr_data[j*XLEN +: XLEN];
  endfunction

  // Highest write port targeting register r this cycle, or -1 if none does
  function automatic int last_writer(input int r);
    for (int j = NWR - 1; j >= 0; j--)
      if (wr_en[j] && wa(j) == r && r != 0) return j;
    return -1;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // State change at the clock edge, computed register by register
  task automatic m_edge();
    if (reset) m_clear();
    else
      for (int r = 1; r < NREG; r++) begin
        int  w;
        bit  issued;
        w      = last_writer(r);
        issued = issue_valid && int'(issue_rd) == r;
        if (w >= 0) m_reg[r] = wd(w);
        m_busy[r] = issued ? 1'b1 : ((w >= 0) ? 1'b0 : m_busy[r]);
      end
  endtask

  task automatic exp_rd(input int a, output logic [XLEN-1:0] d, output logic b);
    int w;
    if (reset || a == 0) begin
      d = '0;
      b = 1'b0;
    end else begin
      d = m_reg[a];
      b = m_busy[a];
      if (BYP) begin
        w = last_writer(a);
        if (w >= 0) begin
          d = wd(w);
          b = issue_valid && int'(issue_rd) == a;
        end
      end
    end
  endtask

  task automatic set_in(input logic [1:0] we, input logic [3:0] a0, input logic [31:0] d0,
                        input logic [3:0] a1, input logic [31:0] d1, input logic iv,
                        input logic [3:0] ird, input logic [3:0] r0, input logic [3:0] r1,
                        input logic [3:0] r2);
    wr_en       = we;
    wr_addr     = {a1, a0};
    wr_data     = {d1, d0};
    issue_valid = iv;
    issue_rd    = ird;
    rd_addr     = {r2, r1, r0};
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [XLEN-1:0] d;
    logic            b;
    for (int i = 0; i < NRD; i++) begin
      exp_rd(int'(rd_addr[i*AW +: AW]), d, b);
      chk($sformatf("%s_rd_data%0d", tag, i), 64'(rd_data[i*XLEN +: XLEN]), 64'(d));
      chk($sformatf("%s_rd_busy%0d", tag, i), 64'(rd_busy[i]), 64'(b));
    end
    for (int r = 0; r < NREG; r++)
      chk($sformatf("%s_dbg%0d", tag, r), 64'(dbg_regs[r*XLEN +: XLEN]), 64'(m_reg[r]));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  we;
    logic [3:0]  wa0;
    logic [31:0] wd0;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        iv;
    logic [3:0]  ird;
    logic [3:0]  ra0, ra1, ra2;
    logic [31:0] e0, e1, e2;
    logic [2:0]  eb;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{2'b11, 4'd5, 32'h1111, 4'd5, 32'h2222, 1'b0, 4'd0, 4'd5, 4'd0, 4'd1,
                BYP ? 32'h2222 : 32'h0, 32'h0, 32'h0, 3'b000};
    tbl[1]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd5, 4'd0,
                32'h2222, 32'h2222, 32'h0, 3'b000};
    tbl[2]  = '{2'b01, 4'd0, 32'hDEAD, 4'd0, 32'h0, 1'b1, 4'd0, 4'd0, 4'd5, 4'd0,
                32'h0, 32'h2222, 32'h0, 3'b000};
    tbl[3]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0,
                32'h0, 32'h0, 32'h0, 3'b000};
    tbl[4]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd7, 4'd7, 4'd5,
                32'h0, 32'h0, 32'h2222, 3'b000};
    tbl[5]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd0, 4'd5,
                32'h0, 32'h0, 32'h2222, 3'b001};
    tbl[6]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd0, 4'd5,
                32'h0, 32'h0, 32'h2222, 3'b001};
    tbl[7]  = '{2'b10, 4'd0, 32'h0, 4'd7, 32'h42, 1'b0, 4'd0, 4'd7, 4'd5, 4'd0,
                BYP ? 32'h42 : 32'h0, 32'h2222, 32'h0, BYP ? 3'b000 : 3'b001};
    tbl[8]  = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd7, 4'd0,
                32'h42, 32'h42, 32'h0, 3'b000};
    tbl[9]  = '{2'b01, 4'd7, 32'h55, 4'd0, 32'h0, 1'b1, 4'd7, 4'd7, 4'd5, 4'd7,
                BYP ? 32'h55 : 32'h42, 32'h2222, BYP ? 32'h55 : 32'h42, BYP ? 3'b101 : 3'b000};
    tbl[10] = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd15, 4'd1,
                32'h55, 32'h0, 32'h0, 3'b001};
    tbl[11] = '{2'b11, 4'd15, 32'hAAAA0001, 4'd1, 32'h0000BEEF, 1'b0, 4'd0, 4'd15, 4'd15, 4'd1,
                BYP ? 32'hAAAA0001 : 32'h0, BYP ? 32'hAAAA0001 : 32'h0,
                BYP ? 32'h0000BEEF : 32'h0, 3'b000};
    tbl[12] = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd15, 4'd15, 4'd1,
                32'hAAAA0001, 32'hAAAA0001, 32'h0000BEEF, 3'b000};
    tbl[13] = '{2'b11, 4'd9, 32'h1, 4'd9, 32'h2, 1'b1, 4'd9, 4'd9, 4'd7, 4'd15,
                BYP ? 32'h2 : 32'h0, 32'h55, 32'hAAAA0001, BYP ? 3'b011 : 3'b010};
    tbl[14] = '{2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd9, 4'd9, 4'd7,
                32'h2, 32'h2, 32'h55, 3'b111};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] old3;

    // Reset with writes and an issue held: everything reads zero
    reset = 1'b1;
    m_clear();
    set_in(2'b11, 4'd3, 32'hFFFF_FFFF, 4'd4, 32'h1234_5678, 1'b1, 4'd6, 4'd3, 4'd4, 4'd6);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("rst_rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]), 64'h0);
        chk($sformatf("rst_rd_busy%0d", i), 64'(rd_busy[i]), 64'h0);
      end
      for (int r = 0; r < NREG; r++)
        chk($sformatf("rst_dbg%0d", r), 64'(dbg_regs[r*XLEN +: XLEN]), 64'h0);
      tick();
    end
    set_in(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd4, 4'd6);
    reset = 1'b0;
    @(negedge clk);
    check_model("post_rst");
    tick();

    // Directed vectors
    for (int k = 0; k < 15; k++) begin
      set_in(tbl[k].we, tbl[k].wa0, tbl[k].wd0, tbl[k].wa1, tbl[k].wd1, tbl[k].iv,
             tbl[k].ird, tbl[k].ra0, tbl[k].ra1, tbl[k].ra2);
      @(negedge clk);
      chk($sformatf("tbl%0d_d0", k), 64'(rd_data[0*XLEN +: XLEN]), 64'(tbl[k].e0));
      chk($sformatf("tbl%0d_d1", k), 64'(rd_data[1*XLEN +: XLEN]), 64'(tbl[k].e1));
      chk($sformatf("tbl%0d_d2", k), 64'(rd_data[2*XLEN +: XLEN]), 64'(tbl[k].e2));
      chk($sformatf("tbl%0d_busy", k), 64'(rd_busy), 64'(tbl[k].eb));
      tick();
    end

    // Same-cycle write and read of x3; the debug image changes only after the edge
    old3 = m_reg[3];
    set_in(2'b01, 4'd3, 32'hABCD, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3, 4'd3, 4'd0);
    @(negedge clk);
    chk("x3_same_cycle_rd", 64'(rd_data[0*XLEN +: XLEN]), BYP ? 64'hABCD : 64'(old3));
    chk("x3_same_cycle_dbg", 64'(dbg_regs[3*XLEN +: XLEN]), 64'(old3));
    tick();
    set_in(2'b01, 4'd0, 32'hDEAD, 4'd0, 32'h0, 1'b1, 4'd0, 4'd3, 4'd0, 4'd0);
    @(negedge clk);
    chk("x3_after_edge_rd", 64'(rd_data[0*XLEN +: XLEN]), 64'hABCD);
    chk("x3_after_edge_dbg", 64'(dbg_regs[3*XLEN +: XLEN]), 64'hABCD);
    tick();
    set_in(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("x0_dbg", 64'(dbg_regs[0*XLEN +: XLEN]), 64'h0);
    chk("x0_busy", 64'(rd_busy[0]), 64'h0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic [3:0] a0, a1;
      a0 = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
      set_in(2'($urandom_range(0, 3)), a0, $urandom, a1, $urandom,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0) ? a0 : 4'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 0) ? a0 : 4'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 0) ? a1 : 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)));
      @(negedge clk);
      check_model("rand");
      tick();
    end

    // Reset asserted mid-cycle overrides the pending write and issue
    set_in(2'b11, 4'd2, 32'h77, 4'd6, 32'h99, 1'b1, 4'd2, 4'd2, 4'd6, 4'd15);
    #2;
    reset = 1'b1;
    m_clear();
    #1;
    check_model("midrst");
    tick();
    set_in(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd2, 4'd6, 4'd15);
    reset = 1'b0;
    @(negedge clk);
    check_model("after_midrst");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
